// File: rtl/debounce_bank.sv
// Multi-channel switch debouncer: synchroniser, per-channel stability counter,
// registered press / release / long-press event pulses.
module debounce_bank #(
  parameter int unsigned N_CH           = 4,
  parameter int unsigned DEBOUNCE_LIMIT = 250000,
  parameter int unsigned HOLD_LIMIT     = 25000000,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter bit          RESET_LEVEL    = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] i_switch,
  output logic [N_CH-1:0] o_switch,
  output logic [N_CH-1:0] o_rise,
  output logic [N_CH-1:0] o_fall,
  output logic [N_CH-1:0] o_hold
);

  localparam int unsigned CNT_W    = (DEBOUNCE_LIMIT > 32'd1) ? $clog2(DEBOUNCE_LIMIT) : 32'd1;
  localparam int unsigned HOLD_W   = (HOLD_LIMIT > 32'd0) ? $clog2(HOLD_LIMIT + 32'd1) : 32'd1;
  localparam int unsigned HOLD_PRE_INT = (HOLD_LIMIT > 32'd0) ? (HOLD_LIMIT - 32'd1) : 32'd0;

  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEBOUNCE_LIMIT - 32'd1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(32'd1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_LIMIT);
  localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(HOLD_PRE_INT);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(32'd1);
  localparam logic [N_CH-1:0]   RST_VEC  = {N_CH{RESET_LEVEL}};

  logic [N_CH-1:0] sync_q [SYNC_STAGES];
  logic [N_CH-1:0] sample_s;

  // Input synchroniser chain, all channels in parallel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= RST_VEC;
      end
    end else begin
      sync_q[0] <= i_switch;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign sample_s = sync_q[SYNC_STAGES-1];

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             sw_q;
    logic             sw_d;
    logic             rise_q;
    logic             rise_d;
    logic             fall_q;
    logic             fall_d;

    // A mismatching sample must persist DEBOUNCE_LIMIT edges; any match restarts the count.
    always_comb begin
      cnt_d  = {CNT_W{1'b0}};
      sw_d   = sw_q;
      rise_d = 1'b0;
      fall_d = 1'b0;
      if (sample_s[c] == sw_q) begin
        cnt_d = {CNT_W{1'b0}};
      end else if (cnt_q == CNT_MAX) begin
        cnt_d  = {CNT_W{1'b0}};
        sw_d   = sample_s[c];
        rise_d = sample_s[c];
        fall_d = ~sample_s[c];
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end

    // Debounced level, stability counter and edge pulses.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q  <= {CNT_W{1'b0}};
        sw_q   <= RESET_LEVEL;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        sw_q   <= sw_d;
        rise_q <= rise_d;
        fall_q <= fall_d;
      end
    end

    assign o_switch[c] = sw_q;
    assign o_rise[c]   = rise_q;
    assign o_fall[c]   = fall_q;

    if (HOLD_LIMIT > 32'd0) begin : g_hold
      logic [HOLD_W-1:0] hcnt_q;
      logic [HOLD_W-1:0] hcnt_d;
      logic              hold_q;
      logic              hold_d;

      // Saturating press-duration counter; the pulse fires on the step into saturation,
      // unless a release is being accepted on the same edge.
      always_comb begin
        hcnt_d = hcnt_q;
        hold_d = 1'b0;
        if (!sw_q) begin
          hcnt_d = {HOLD_W{1'b0}};
        end else if (hcnt_q != HOLD_MAX) begin
          hcnt_d = hcnt_q + HOLD_ONE;
          hold_d = (hcnt_q == HOLD_PRE) && !fall_d;
        end else begin
          hcnt_d = hcnt_q;
        end
      end

      // Hold counter and long-press pulse register.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          hcnt_q <= {HOLD_W{1'b0}};
          hold_q <= 1'b0;
        end else begin
          hcnt_q <= hcnt_d;
          hold_q <= hold_d;
        end
      end

      assign o_hold[c] = hold_q;
    end else begin : g_no_hold
      assign o_hold[c] = 1'b0;
    end
  end

endmodule
